ps2_kbd_event_fifo: RTL and testbench

//  Parametrised successor PS/2 keyboard receiver: filters and synchronises ps2_clk, deframes 11-bit

---
 rtl/ps2_kbd_event_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_kbd_event_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 keyboard receiver: deglitch + deframe + E0/F0 decode into a key-event FIFO popped by nextdata_n.
// Event visible 2 clk after the stop-bit sample; no backpressure to the keyboard, full FIFO drops and flags overflow.

module ps2_kbd_event_fifo_buf #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop & ~empty;
   // A pop frees the head slot in the same cycle, so a full buffer still takes a simultaneous push.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

module ps2_kbd_event_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic       ready,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       overflow,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_s;
   logic          dat_s;
   logic [FW-1:0] flt_cnt;
   logic          flt_clk;
   logic          flt_prev;
   logic          sample;

   logic [3:0]    bit_cnt;
   logic [9:0]    frame_bits;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic          stop_sample;
   logic          frame_ok;
   logic          byte_vld;
   logic [7:0]    byte_dat;

   logic          pend_ext;
   logic          pend_brk;
   logic          is_ext;
   logic          is_brk;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic [9:0]    head;

   // Pins idle high; resetting the synchronisers to 1 avoids a phantom falling edge out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
      end
   end

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         flt_cnt  <= '0;
         flt_clk  <= 1'b1;
         flt_prev <= 1'b1;
      end else begin
         flt_prev <= flt_clk;
         if (clk_s == flt_clk) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_MAX) begin
            flt_clk <= clk_s;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign sample      = flt_prev & ~flt_clk;
   assign stop_sample = sample && (bit_cnt == 4'd10);
   assign frame_ok    = ~frame_bits[0] & dat_s & (^frame_bits[9:1]);
   assign timeout     = ~sample && (bit_cnt != 4'd0) && (to_cnt == TO_MAX);

   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt    <= '0;
         frame_bits <= '0;
         to_cnt     <= '0;
         byte_vld   <= 1'b0;
         byte_dat   <= '0;
      end else begin
         byte_vld <= 1'b0;
         if (sample) begin
            to_cnt <= '0;
            if (stop_sample) begin
               bit_cnt  <= '0;
               byte_vld <= frame_ok;
               byte_dat <= frame_bits[8:1];
            end else begin
               frame_bits[bit_cnt] <= dat_s;
               bit_cnt             <= bit_cnt + 1'b1;
            end
         end else if (timeout) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else if (bit_cnt != 4'd0) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
      end
   end

   assign is_ext = (byte_dat == 8'hE0);
   assign is_brk = (byte_dat == 8'hF0);
   assign push   = byte_vld & ~is_ext & ~is_brk;
   assign pop    = ready & ~nextdata_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_ext  <= 1'b0;
         pend_brk  <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if ((stop_sample && !frame_ok) || timeout) begin
            frame_err <= 1'b1;
            pend_ext  <= 1'b0;
            pend_brk  <= 1'b0;
         end else if (byte_vld) begin
            if (is_ext) begin
               pend_ext <= 1'b1;
            end else if (is_brk) begin
               pend_brk <= 1'b1;
            end else begin
               pend_ext <= 1'b0;
               pend_brk <= 1'b0;
            end
         end
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   ps2_kbd_event_fifo_buf #(
      .WIDTH (10),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({pend_ext, pend_brk, byte_dat}),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Key fields read as zero while empty so stale storage never leaks out.
   assign ready                          = ~fifo_empty;
   assign {key_ext, key_break, key_code} = ready ? head : 10'd0;
endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// Bench for ps2_kbd_event_fifo: drives PS/2 frames bit by bit and tracks expected events in a queue model.
module tb_ps2_kbd_event_fifo;
   localparam int DEPTH = 8;
   localparam int FLT   = 4;
   localparam int TMO   = 5000;
   localparam int HP    = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic       ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       overflow;
   logic       frame_err;

   int         n_checks = 0;
   int         n_fail = 0;
   int         lat = 9;
   bit         settled = 1'b0;

   logic [9:0] q[$];
   bit         m_ovf, m_err, pe, pb;

   always #5 clk = ~clk;

   ps2_kbd_event_fifo #(
      .FIFO_DEPTH  (DEPTH),
      .FILTER_LEN  (FLT),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .ready      (ready),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_break  (key_break),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Whenever the model is in step with the DUT, every cycle is compared against it.
   always @(negedge clk) begin
      if (settled) begin
         chk1("ready", ready, q.size() != 0);
         if (q.size() != 0) chk10("head", {key_ext, key_break, key_code}, q[0]);
         chk1("overflow", overflow, m_ovf);
         chk1("frame_err", frame_err, m_err);
      end
   end

   task automatic model_frame(input logic [7:0] b, input bit bad, input bit popped);
      if (popped && q.size() > 0) q.delete(0);
      if (bad) begin
         m_err = 1'b1;
         pe = 1'b0;
         pb = 1'b0;
      end else if (b == 8'hE0) begin
         pe = 1'b1;
      end else if (b == 8'hF0) begin
         pb = 1'b1;
      end else begin
         if (q.size() < DEPTH) q.push_back({pe, pb, b});
         else m_ovf = 1'b1;
         pe = 1'b0;
         pb = 1'b0;
      end
   endtask

   task automatic do_reset();
      settled = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      pe = 1'b0;
      pb = 1'b0;
      @(negedge clk);
      settled = 1'b1;
   endtask

   task automatic pop_n(input int n);
      @(negedge clk);
      nextdata_n = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (q.size() > 0) q.delete(0);
      end
      nextdata_n = 1'b1;
   endtask

   // mode 0: plain; 1: measure stop-edge-to-ready latency; 2: pop in the push cycle
   task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits,
                             input int glitch_at, input int mode);
      logic [10:0] bits;
      int k;
      settled = 1'b0;
      bits = {1'b1, (~(^b)) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         if (i == glitch_at) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FLT - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HP - 8 - (FLT - 2)) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         ps2_clk = 1'b0;
         if (i == 10 && mode == 1) begin
            k = 0;
            while (ready !== 1'b1 && k < HP) begin
               @(negedge clk);
               k++;
            end
            n_checks++;
            if (ready !== 1'b1) begin
               n_fail++;
               $display("FAIL latency: ready=%b after %0d cycles, expected 1", ready, k);
            end else begin
               lat = k;
            end
            repeat (HP - k) @(negedge clk);
         end else if (i == 10 && mode == 2) begin
            repeat (lat - 1) @(negedge clk);
            nextdata_n = 1'b0;
            @(negedge clk);
            nextdata_n = 1'b1;
            repeat (HP - lat) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      if (nbits == 11) begin
         repeat (30) @(negedge clk);
         model_frame(b, bad, mode == 2);
         settled = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] b;
      int r;
      int g;

      do_reset();
      chk1("rst_ready", ready, 1'b0);
      chk10("rst_key", {key_ext, key_break, key_code}, 10'h000);
      chk1("rst_ovf", overflow, 1'b0);
      chk1("rst_err", frame_err, 1'b0);

      send_frame(8'h1C, 1'b0, 11, -1, 1);
      chk1("make_ready", ready, 1'b1);
      chk10("make_event", {key_ext, key_break, key_code}, 10'h01C);
      pop_n(1);
      @(negedge clk);
      chk1("make_popped", ready, 1'b0);

      send_frame(8'hF0, 1'b0, 11, -1, 0);
      chk1("brk_prefix_only", ready, 1'b0);
      send_frame(8'h1C, 1'b0, 11, -1, 0);
      chk10("brk_event", {key_ext, key_break, key_code}, 10'h11C);
      pop_n(1);
      @(negedge clk);
      chk1("brk_single", ready, 1'b0);

      send_frame(8'hE0, 1'b0, 11, -1, 0);
      send_frame(8'hF0, 1'b0, 11, -1, 0);
      send_frame(8'h75, 1'b0, 11, -1, 0);
      chk10("ext_brk_event", {key_ext, key_break, key_code}, 10'h375);
      pop_n(1);
      @(negedge clk);
      chk1("ext_brk_single", ready, 1'b0);

      send_frame(8'h1C, 1'b1, 11, -1, 0);
      chk1("parity_err", frame_err, 1'b1);
      chk1("parity_dropped", ready, 1'b0);
      send_frame(8'h32, 1'b0, 11, -1, 0);
      chk10("after_err_event", {key_ext, key_break, key_code}, 10'h032);
      pop_n(1);

      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h10 + 8'(i), 1'b0, 11, -1, 0);
      chk1("ovf_set", overflow, 1'b1);
      chk10("ovf_head", {key_ext, key_break, key_code}, 10'h010);
      pop_n(DEPTH + 2);
      @(negedge clk);
      chk1("ovf_drained", ready, 1'b0);

      do_reset();
      for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b0, 11, -1, 0);
      chk1("full_no_ovf", overflow, 1'b0);
      send_frame(8'h28, 1'b0, 11, -1, 2);
      chk1("pushpop_no_ovf", overflow, 1'b0);
      chk10("pushpop_head", {key_ext, key_break, key_code}, 10'h021);
      pop_n(DEPTH + 1);
      @(negedge clk);
      chk1("pushpop_drained", ready, 1'b0);

      do_reset();
      send_frame(8'hE0, 1'b0, 11, -1, 0);
      send_frame(8'h2A, 1'b0, 5, -1, 0);
      repeat (TMO + 200) @(negedge clk);
      m_err = 1'b1;
      pe = 1'b0;
      pb = 1'b0;
      settled = 1'b1;
      @(negedge clk);
      chk1("timeout_err", frame_err, 1'b1);
      chk1("timeout_empty", ready, 1'b0);
      send_frame(8'h2A, 1'b0, 11, -1, 0);
      chk10("timeout_resync", {key_ext, key_break, key_code}, 10'h02A);

      do_reset();
      send_frame(8'h5A, 1'b0, 11, 4, 0);
      chk10("glitch_event", {key_ext, key_break, key_code}, 10'h05A);
      chk1("glitch_no_err", frame_err, 1'b0);

      send_frame(8'h33, 1'b0, 6, -1, 0);
      do_reset();
      chk1("midreset_empty", ready, 1'b0);
      send_frame(8'h32, 1'b0, 11, -1, 0);
      chk10("midreset_event", {key_ext, key_break, key_code}, 10'h032);
      pop_n(1);

      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2)      b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else            b = 8'($urandom_range(0, 255));
         g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
         send_frame(b, $urandom_range(0, 7) == 0, 11, g, 0);
         if ($urandom_range(0, 2) == 0) pop_n(int'($urandom_range(1, 3)));
      end
      pop_n(DEPTH + 1);
      repeat (5) @(negedge clk);
      settled = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
